// File: rtl/scpu_sram_pkg.sv
// Shared constants, mode encodings and FSM state encoding for the serial SRAM
// shift controller.
package scpu_sram_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 8;
    localparam int REG_BITS_DEF = ADDR_W_DEF + DATA_W_DEF;
    localparam int CNT_W_DEF    = $clog2(REG_BITS_DEF);

    // Encoded as {ctrl_mod1, ctrl_mod0}; bit 0 selects SRAM access vs serial transfer.
    typedef enum logic [1:0] {
        MODE_SIN  = 2'b00,
        MODE_RD   = 2'b01,
        MODE_SOUT = 2'b10,
        MODE_WR   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        SHIFT_OUT = 3'd2,
        RD_REQ    = 3'd3,
        RD_CAP    = 3'd4,
        WR        = 3'd5,
        DONE      = 3'd6
    } state_e;

endpackage

// File: rtl/scpu_serial_shreg.sv
// {addr,data} shift register with bit counter: right shift with selectable MSB fill,
// parallel load of the data field and address-field increment.
module scpu_serial_shreg
    import scpu_sram_pkg::*;
#(
    parameter int REG_W  = REG_BITS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              shift_i,
    input  logic              fill_i,
    input  logic              cap_i,
    input  logic [DATA_W-1:0] cap_data_i,
    input  logic              inc_i,
    input  logic              cnt_load_i,
    input  logic [CNT_W-1:0]  cnt_val_i,
    input  logic              cnt_dec_i,
    output logic [REG_W-1:0]  shreg_o,
    output logic [CNT_W-1:0]  cnt_o
);

    localparam int ADDR_W = REG_W - DATA_W;

    logic [REG_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Capture and increment may coincide on a read completion; both apply.
    always_comb begin
        shreg_d = shreg_q;
        if (shift_i) begin
            shreg_d = {fill_i, shreg_q[REG_W-1:1]};
        end
        if (cap_i) begin
            shreg_d[DATA_W-1:0] = cap_data_i;
        end
        if (inc_i) begin
            shreg_d[REG_W-1:DATA_W] = shreg_d[REG_W-1:DATA_W] + ADDR_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load_i) begin
            cnt_d = cnt_val_i;
        end else if (cnt_dec_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shreg_o = shreg_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/scpu_sram_shift_ctrl.sv
// Serial-loaded SRAM access controller. Define SCPU_SRAM_AUTOINC_EN to make the
// address field advance by one after every completed read or write.
module scpu_sram_shift_ctrl
    import scpu_sram_pkg::*;
#(
    parameter int MEMORY_ADDR_WIDTH = ADDR_W_DEF,
    parameter int MEMORY_DATA_WIDTH = DATA_W_DEF,
    parameter int REG_BITS_WIDTH    = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH
) (
    input  logic                         csi_clk,
    input  logic                         rsi_reset_n,
    input  logic                         ctrl_bgn,
    input  logic                         ctrl_load,
    input  logic                         ctrl_mod0,
    input  logic                         ctrl_mod1,
    input  logic                         ctrl_si,
    output logic                         ctrl_so,
    output logic                         ctrl_rdy,
    output logic                         sram_cen_n,
    output logic                         sram_wen_n,
    output logic [MEMORY_ADDR_WIDTH-1:0] sram_a,
    output logic [MEMORY_DATA_WIDTH-1:0] sram_d,
    input  logic [MEMORY_DATA_WIDTH-1:0] sram_q
);

    localparam int CNT_W = $clog2(REG_BITS_WIDTH);

`ifdef SCPU_SRAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    state_e state_q;
    mode_e  mode_q;
    mode_e  mode;
    logic   cen_n_q, wen_n_q, rdy_q;

    logic [REG_BITS_WIDTH-1:0] shreg;
    logic [CNT_W-1:0]          cnt;

    logic idle, start_sin, start_sout, start_rd, start_wr, shifting, last_bit;
    logic sh_shift, sh_fill, sh_cap, sh_inc, cnt_load;
    logic [CNT_W-1:0] cnt_val;

    assign mode       = mode_e'({ctrl_mod1, ctrl_mod0});
    assign idle       = (state_q == IDLE);
    assign start_sin  = idle && ctrl_load && (mode == MODE_SIN);
    assign start_sout = idle && ctrl_load && (mode == MODE_SOUT);
    assign start_rd   = idle && ctrl_bgn  && (mode == MODE_RD);
    assign start_wr   = idle && ctrl_bgn  && (mode == MODE_WR);
    assign shifting   = (state_q == SHIFT_IN) || (state_q == SHIFT_OUT);
    assign last_bit   = (cnt == CNT_W'(1));

    // The start edge already performs the first shift, so the counter covers the rest.
    assign sh_shift = start_sin || start_sout || shifting;
    assign sh_fill  = ctrl_si && (idle ? (mode == MODE_SIN) : (mode_q == MODE_SIN));
    assign sh_cap   = (state_q == RD_CAP);
    assign sh_inc   = AUTOINC && ((state_q == RD_CAP) || (state_q == WR));
    assign cnt_load = start_sin || start_sout;
    assign cnt_val  = start_sin ? CNT_W'(REG_BITS_WIDTH - 1) : CNT_W'(REG_BITS_WIDTH - 2);

    scpu_serial_shreg #(
        .REG_W  (REG_BITS_WIDTH),
        .DATA_W (MEMORY_DATA_WIDTH),
        .CNT_W  (CNT_W)
    ) u_shreg (
        .clk_i      (csi_clk),
        .rst_ni     (rsi_reset_n),
        .shift_i    (sh_shift),
        .fill_i     (sh_fill),
        .cap_i      (sh_cap),
        .cap_data_i (sram_q),
        .inc_i      (sh_inc),
        .cnt_load_i (cnt_load),
        .cnt_val_i  (cnt_val),
        .cnt_dec_i  (shifting),
        .shreg_o    (shreg),
        .cnt_o      (cnt)
    );

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_SIN;
            cen_n_q <= 1'b1;
            wen_n_q <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_sin || start_sout || start_rd || start_wr) begin
                        mode_q <= mode;
                        rdy_q  <= 1'b0;
                    end
                    if (start_sin) begin
                        state_q <= SHIFT_IN;
                    end else if (start_sout) begin
                        state_q <= SHIFT_OUT;
                    end else if (start_rd) begin
                        state_q <= RD_REQ;
                        cen_n_q <= 1'b0;
                        wen_n_q <= 1'b1;
                    end else if (start_wr) begin
                        state_q <= WR;
                        cen_n_q <= 1'b0;
                        wen_n_q <= 1'b0;
                    end
                end
                SHIFT_IN, SHIFT_OUT: begin
                    if (last_bit) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                    end
                end
                RD_REQ: begin
                    state_q <= RD_CAP;
                    cen_n_q <= 1'b1;
                end
                RD_CAP: begin
                    state_q <= DONE;
                    rdy_q   <= 1'b1;
                end
                WR: begin
                    state_q <= DONE;
                    cen_n_q <= 1'b1;
                    wen_n_q <= 1'b1;
                    rdy_q   <= 1'b1;
                end
                DONE: begin
                    if (!ctrl_bgn) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cen_n_q <= 1'b1;
                    wen_n_q <= 1'b1;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign ctrl_so    = shreg[0];
    assign ctrl_rdy   = rdy_q;
    assign sram_cen_n = cen_n_q;
    assign sram_wen_n = wen_n_q;
    assign sram_a     = shreg[REG_BITS_WIDTH-1:MEMORY_DATA_WIDTH];
    assign sram_d     = shreg[MEMORY_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_scpu_sram_shift_ctrl.sv
// Randomized bench for scpu_sram_shift_ctrl with an operation-level reference model
// checked every cycle, plus directed literal checks.
module tb_scpu_sram_shift_ctrl;

`ifdef SCPU_SRAM_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, bgn, load, mod0, mod1, si;
    logic       so, rdy, cen_n, wen_n;
    logic [9:0] a;
    logic [7:0] d, q;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 1'b0;

    // Reference model: what operation is in progress and how many edges it still needs.
    typedef enum int {K_IDLE, K_SIN, K_SOUT, K_RD, K_WR, K_DONE} kind_e;
    kind_e       m_kind;
    int          m_left;
    logic [17:0] m_sh;
    logic        m_cen, m_wen, m_rdy;

    scpu_sram_shift_ctrl dut (
        .csi_clk     (clk),
        .rsi_reset_n (rst_n),
        .ctrl_bgn    (bgn),
        .ctrl_load   (load),
        .ctrl_mod0   (mod0),
        .ctrl_mod1   (mod1),
        .ctrl_si     (si),
        .ctrl_so     (so),
        .ctrl_rdy    (rdy),
        .sram_cen_n  (cen_n),
        .sram_wen_n  (wen_n),
        .sram_a      (a),
        .sram_d      (d),
        .sram_q      (q)
    );

    initial forever #5 clk = ~clk;

    task automatic model_reset();
        m_kind = K_IDLE;
        m_left = 0;
        m_sh   = '0;
        m_cen  = 1'b1;
        m_wen  = 1'b1;
        m_rdy  = 1'b1;
    endtask

    task automatic finish_access();
        if (AUTOINC) m_sh[17:8] = m_sh[17:8] + 10'd1;
        m_kind = K_DONE;
        m_rdy  = 1'b1;
    endtask

    task automatic model_step();
        logic [1:0] md;
        md = {mod1, mod0};
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_kind)
            K_IDLE: begin
                if (load && !md[0]) begin
                    m_sh   = {(md == 2'b00) ? si : 1'b0, m_sh[17:1]};
                    m_kind = (md == 2'b00) ? K_SIN : K_SOUT;
                    m_left = (md == 2'b00) ? 17 : 16;
                    m_rdy  = 1'b0;
                end else if (bgn && md[0]) begin
                    m_kind = md[1] ? K_WR : K_RD;
                    m_left = md[1] ? 1 : 2;
                    m_cen  = 1'b0;
                    m_wen  = !md[1];
                    m_rdy  = 1'b0;
                end
            end
            K_SIN, K_SOUT: begin
                m_sh = {(m_kind == K_SIN) ? si : 1'b0, m_sh[17:1]};
                m_left--;
                if (m_left == 0) begin
                    m_kind = K_IDLE;
                    m_rdy  = 1'b1;
                end
            end
            K_RD: begin
                m_left--;
                if (m_left == 1) begin
                    m_cen = 1'b1;
                end else begin
                    m_sh[7:0] = q;
                    finish_access();
                end
            end
            K_WR: begin
                m_cen = 1'b1;
                m_wen = 1'b1;
                finish_access();
            end
            K_DONE: if (!bgn) m_kind = K_IDLE;
            default: m_kind = K_IDLE;
        endcase
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            vectors++;
            if ({so, rdy, cen_n, wen_n, a, d} !== {m_sh[0], m_rdy, m_cen, m_wen, m_sh}) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t actual so=%b rdy=%b cen_n=%b wen_n=%b a=%h d=%h required so=%b rdy=%b cen_n=%b wen_n=%b a=%h d=%h",
                         $time, so, rdy, cen_n, wen_n, a, d, m_sh[0], m_rdy, m_cen, m_wen, m_sh[17:8], m_sh[7:0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_word(input logic [17:0] w);
        for (int i = 0; i < 18; i++) begin
            load = (i == 0);
            mod0 = 1'b0;
            mod1 = 1'b0;
            si   = w[i];
            tick();
        end
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; bgn = 1'b0; load = 1'b0; mod0 = 1'b0; mod1 = 1'b0; si = 1'b0; q = '0;
        model_reset();
        repeat (3) tick();
        chk_en = 1'b1;
        chk("reset_outputs", {so, rdy, cen_n, wen_n, a, d}, {1'b0, 1'b1, 1'b1, 1'b1, 18'h0});
        rst_n = 1'b1;

        // Shift-in accepted on the first edge after reset release.
        shift_word(18'h155A5);
        chk("sin_addr", a, 10'h155);
        chk("sin_data", d, 8'hA5);
        chk("sin_rdy", rdy, 1'b1);

        // Write with bgn held high through DONE.
        bgn = 1'b1; mod1 = 1'b1; mod0 = 1'b1;
        tick();
        chk("wr_strobe", {cen_n, wen_n, rdy}, 3'b000);
        chk("wr_addr", {a, d}, {10'h155, 8'hA5});
        tick();
        chk("wr_done", {cen_n, wen_n, rdy}, 3'b111);
        chk("wr_addr_after", a, AUTOINC ? 10'h156 : 10'h155);
        mod1 = 1'b0; mod0 = 1'b0; load = 1'b1;
        tick();
        chk("done_hold_rdy", rdy, 1'b1);
        load = 1'b0; bgn = 1'b0;
        tick();

        // Read from address 0x3FF.
        shift_word(18'h3FF00);
        q = 8'h5A; bgn = 1'b1; mod1 = 1'b0; mod0 = 1'b1;
        tick();
        chk("rd_req", {cen_n, wen_n, rdy}, 3'b010);
        tick();
        chk("rd_cap", {cen_n, rdy}, 2'b10);
        tick();
        chk("rd_data", d, 8'h5A);
        chk("rd_addr", a, AUTOINC ? 10'h000 : 10'h3FF);
        chk("rd_rdy", rdy, 1'b1);
        bgn = 1'b0;
        tick();

        // Shift-out of 0x2AAAA, LSB first.
        shift_word(18'h2AAAA);
        chk("sout_bit0", so, 1'b0);
        load = 1'b1; mod1 = 1'b1; mod0 = 1'b0;
        for (int i = 1; i < 18; i++) begin
            tick();
            load = 1'b0;
            chk("sout_bit", so, 32'(i & 1));
        end
        chk("sout_rdy", rdy, 1'b1);

        // Reset in the middle of a write, then restart with bgn still high.
        shift_word(18'h0F00F);
        bgn = 1'b1; mod1 = 1'b1; mod0 = 1'b1;
        tick();
        chk("wr2_strobe", {cen_n, wen_n}, 2'b00);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_wr", {cen_n, wen_n, rdy, a, d}, {3'b111, 18'h0});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("wr_after_rst", {cen_n, wen_n, rdy}, 3'b000);
        tick();
        bgn = 1'b0;
        tick();

        // Randomized traffic, including mode changes mid-operation and stray requests.
        for (int n = 0; n < 4000; n++) begin
            load = ($urandom_range(0, 5) == 0);
            bgn  = ($urandom_range(0, 9) < 3);
            mod0 = $urandom_range(0, 1) == 1;
            mod1 = $urandom_range(0, 1) == 1;
            si   = $urandom_range(0, 1) == 1;
            q    = 8'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
